seq_mult: RTL
=============

Name: seq_mult

Overview:
- Parametrised sequential radix-2 shift-add multiplier. It is the successor to the fixed 2x2 combinational multiplier.
- Accepts one operand pair through a valid/ready handshake and produces a full-width 2*WIDTH product after a fixed latency.
- Presents the result with valid/ready backpressure.
- Used wherever area matters more than throughput, e.g. datapath scaling and address arithmetic.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2; the product is 2*WIDTH bits.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair a/b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  2*WIDTH  product
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE.
  - in_ready=1 in the following cycle; out_valid=0, result=0, busy=0.
  - All internal registers (accumulator, shifted multiplicand, multiplier shift register, bit counter) are cleared.
- FSM states: IDLE, CALC, DONE. Outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a and b, clear the accumulator, set count=0, go to CALC.
  - in_valid=0: stay in IDLE.
- CALC:
  - in_ready=0, busy=1.
  - Each edge: if the multiplier LSB is 1, accumulator += multiplicand. Then shift the multiplicand left 1, shift the multiplier right 1, and increment count.
  - After exactly WIDTH CALC edges, load the final accumulator into result and go to DONE.
  - Inputs are ignored while in CALC.
- DONE:
  - out_valid=1, result stable, in_ready=0.
  - On an edge with out_ready=1: go to IDLE and set out_valid=0. result holds its value until the next load.
  - out_ready=0: hold in DONE indefinitely.
- Latency:
  - Accept edge at T; out_valid is first high in the cycle after edge T+WIDTH, a fixed latency of WIDTH cycles.
  - Minimum initiation interval is WIDTH+2 cycles when out_ready is held at 1.
- Width rules:
  - The accumulator is 2*WIDTH bits; the multiplicand is zero-extended to 2*WIDTH.
  - No overflow is possible. The maximum product (2^WIDTH-1)^2 fits in 2*WIDTH bits.
- Boundaries:
  - A zero operand still takes the full WIDTH cycles; there is no early termination.
  - The count register is ceil(log2(WIDTH+1)) bits and must not wrap before reaching WIDTH.
  - rst asserted during CALC or DONE aborts the operation; no out_valid pulse is produced for it.
  - rst has priority over every handshake.
- Handshake rules:
  - in_valid may be held high across operations; a new pair is accepted only in IDLE.
  - The source must keep a/b stable only on the accept edge.

Optional Feature:
- SEQ_MULT_SIGNED_EN defined:
  - Operands and result are two's complement.
  - On accept, latch the absolute values of a and b plus a sign flag, sign = a[MSB] ^ b[MSB].
  - On the CALC->DONE transition, negate the accumulator if sign=1.
  - Most-negative operands are handled by treating |a| as WIDTH-bit unsigned, e.g. -128 x -128 = 16384 at WIDTH=8.
  - Latency is unchanged.
- SEQ_MULT_SIGNED_EN undefined: unsigned only; no sign logic is synthesised.

Decomposition:
- seq_mult_pkg holds:
  - the state enum typedef (IDLE, CALC, DONE);
  - a count-width helper function;
  - the DEFAULT_WIDTH constant.
- No sub-module; the datapath and FSM fit in one module.

Test Plan:
- WIDTH=8, rst then a=3, b=3 with in_valid for 1 cycle -> out_valid after 8 cycles, result=16'h0009, busy low after handshake.
- WIDTH=8, a=8'hFF, b=8'hFF, out_ready=0 for 5 cycles then 1 -> result=16'hFE01 held stable through the stall; IDLE one cycle after out_ready.
- WIDTH=2, all 16 {a,b} pairs back-to-back with in_valid held high -> results match the 2x2 product table (e.g. 3x3=4'b1001); one operation per WIDTH+2 cycles.
- WIDTH=8, accept a=10, b=20; assert rst at count=4 -> out_valid never rises for this op; next op a=7, b=6 gives result=42.
- WIDTH=8, a=0, b=8'hAB -> result=0 after the full 8-cycle latency; in_ready=0 throughout.
- SEQ_MULT_SIGNED_EN, WIDTH=8: a=-3 (8'hFD), b=5 -> result=16'hFFF1; a=-128, b=-128 -> result=16'h4000.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StDone = 2'd2
   } state_t;

   // Bits needed for a counter that must reach w without wrapping.
   function automatic int unsigned count_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/seq_mult.sv
// Radix-2 shift-add multiplier, one operand bit per cycle, valid/ready on both sides.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands and result.
module seq_mult
   import seq_mult_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               busy
);

   localparam int unsigned CW = count_width(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t             r_state, w_state_next;
   logic [2*WIDTH-1:0] r_acc, r_mcand, r_result;
   logic [2*WIDTH-1:0] w_acc_sum, w_final;
   logic [WIDTH-1:0]   r_mplier, w_a_mag, w_b_mag;
   logic [CW-1:0]      r_count;
   logic               w_last;

`ifdef SEQ_MULT_SIGNED_EN
   logic r_sign;

   // Magnitudes are kept as WIDTH-bit unsigned so the most-negative value maps to 2^(WIDTH-1).
   assign w_a_mag = a[WIDTH-1] ? (-a) : a;
   assign w_b_mag = b[WIDTH-1] ? (-b) : b;
   assign w_final = r_sign ? (-w_acc_sum) : w_acc_sum;
`else
   assign w_a_mag = a;
   assign w_b_mag = b;
   assign w_final = w_acc_sum;
`endif

   assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_last    = (r_count == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (in_valid)  w_state_next = StCalc;
         StCalc:  if (w_last)    w_state_next = StDone;
         StDone:  if (out_ready) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_count  <= '0;
         r_result <= '0;
`ifdef SEQ_MULT_SIGNED_EN
         r_sign   <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            StIdle: begin
               if (in_valid) begin
                  r_acc    <= '0;
                  r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                  r_mplier <= w_b_mag;
                  r_count  <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                  r_sign   <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
               end
            end
            StCalc: begin
               r_acc    <= w_acc_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_count  <= r_count + 1'b1;
               if (w_last) begin
                  r_result <= w_final;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == StIdle);
   assign out_valid = (r_state == StDone);
   assign busy      = (r_state != StIdle);
   assign result    = r_result;

endmodule
